// File: rtl/rpn_lexer.sv
// Purpose: UART 8N1 receiver plus RPN tokeniser (numbers, operators, end-of-line, errors).
// Latency: tokens registered one clock after the stop-bit sample; an operator/eol that closes a number follows one clock later.
// Backpressure: none; bytes arrive at least ten bit times apart, so every token strobe is fire-and-forget.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   rx_in               UART line, idle high, LSB first
//   op_ready / op       operator strobe and code (+ 0, - 1, * 2, / 3, % 4), code held between strobes
//   num_ready / num     number strobe and value, value held between strobes
//   num_ovf             number saturated, qualified by num_ready
//   eol                 end-of-line strobe
//   err                 illegal character or framing error strobe
module rpn_lexer #(
    parameter int CLKS_PER_BIT = 1085,
    parameter int NUM_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    output logic                 op_ready,
    output logic [3:0]           op,
    output logic                 num_ready,
    output logic [NUM_WIDTH-1:0] num,
    output logic                 num_ovf,
    output logic                 eol,
    output logic                 err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    // ------------------------------------------------------------------
    // Synchroniser. Resets to the idle level so a line held low across
    // reset release is seen as a fresh falling edge.
    // ------------------------------------------------------------------
    logic [1:0] rx_sync;
    logic       rx_s;
    logic       rx_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], rx_in};
            rx_prev <= rx_sync[1];
        end
    end

    assign rx_s = rx_sync[1];

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    rx_state_t        rx_state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             bit_due;
    logic             byte_stb;
    logic             frame_err;

    assign bit_due   = (cnt == BIT_LAST);
    // Both strobes fire on the stop-bit sample clock; the lexer registers them.
    assign byte_stb  = (rx_state == RX_STOP) && bit_due && rx_s;
    assign frame_err = (rx_state == RX_STOP) && bit_due && !rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (rx_prev && !rx_s) begin
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // A start bit that is already gone by mid-bit is a glitch.
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (bit_due) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (bit_due) begin
                        cnt      <= '0;
                        rx_state <= rx_s ? RX_IDLE : RX_WAIT_HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    // Do not hunt for a start bit inside a broken frame.
                    if (rx_s) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Character decode
    // ------------------------------------------------------------------
    logic                 is_digit;
    logic                 is_op;
    logic                 is_nl;
    logic                 is_ws;
    logic [3:0]           op_code;
    logic [NUM_WIDTH+3:0] acc_ext;
    logic [NUM_WIDTH+3:0] prod;
    logic                 prod_ovf;
    logic [NUM_WIDTH-1:0] acc;
    logic                 ovf;

    always_comb begin
        is_digit = (shreg >= 8'h30) && (shreg <= 8'h39);
        is_op    = 1'b1;
        op_code  = 4'd0;
        case (shreg)
            8'h2B:   op_code = 4'd0; // +
            8'h2D:   op_code = 4'd1; // -
            8'h2A:   op_code = 4'd2; // *
            8'h2F:   op_code = 4'd3; // /
            8'h25:   op_code = 4'd4; // %
            default: is_op   = 1'b0;
        endcase
        is_nl = (shreg == 8'h0A);
        is_ws = (shreg == 8'h20) || (shreg == 8'h0D);
        // acc*10 + digit; four spare bits hold the worst case of a saturated acc.
        // The ASCII digits' low nibble is the digit value.
        acc_ext  = {4'b0000, acc};
        prod     = (acc_ext << 3) + (acc_ext << 1) + {{NUM_WIDTH{1'b0}}, shreg[3:0]};
        prod_ovf = |prod[NUM_WIDTH+3:NUM_WIDTH];
    end

    // ------------------------------------------------------------------
    // Lexer
    // ------------------------------------------------------------------
    typedef enum logic {
        LX_EMPTY,
        LX_NUM
    } lx_state_t;

    lx_state_t  lx_state;
    logic       pend_op;
    logic [3:0] pend_code;
    logic       pend_eol;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lx_state  <= LX_EMPTY;
            acc       <= '0;
            ovf       <= 1'b0;
            pend_op   <= 1'b0;
            pend_code <= 4'd0;
            pend_eol  <= 1'b0;
            op_ready  <= 1'b0;
            op        <= 4'd0;
            num_ready <= 1'b0;
            num       <= '0;
            num_ovf   <= 1'b0;
            eol       <= 1'b0;
            err       <= 1'b0;
        end else begin
            op_ready  <= 1'b0;
            num_ready <= 1'b0;
            eol       <= 1'b0;
            err       <= 1'b0;

            // Operator/eol held back one clock behind the number it closed.
            if (pend_op) begin
                op_ready <= 1'b1;
                op       <= pend_code;
                pend_op  <= 1'b0;
            end
            if (pend_eol) begin
                eol      <= 1'b1;
                pend_eol <= 1'b0;
            end

            if (frame_err) begin
                // Dropped byte: report it, leave any number in progress intact.
                err <= 1'b1;
            end else if (byte_stb) begin
                if (is_digit) begin
                    lx_state <= LX_NUM;
                    if (ovf || prod_ovf) begin
                        acc <= '1;
                        ovf <= 1'b1;
                    end else begin
                        acc <= prod[NUM_WIDTH-1:0];
                    end
                end else if (is_op || is_nl || is_ws) begin
                    if (lx_state == LX_NUM) begin
                        num_ready <= 1'b1;
                        num       <= acc;
                        num_ovf   <= ovf;
                        acc       <= '0;
                        ovf       <= 1'b0;
                        lx_state  <= LX_EMPTY;
                    end
                    if (is_op) begin
                        if (lx_state == LX_NUM) begin
                            pend_op   <= 1'b1;
                            pend_code <= op_code;
                        end else begin
                            op_ready <= 1'b1;
                            op       <= op_code;
                        end
                    end
                    if (is_nl) begin
                        if (lx_state == LX_NUM) begin
                            pend_eol <= 1'b1;
                        end else begin
                            eol <= 1'b1;
                        end
                    end
                end else begin
                    err      <= 1'b1;
                    acc      <= '0;
                    ovf      <= 1'b0;
                    lx_state <= LX_EMPTY;
                end
            end
        end
    end

endmodule

// File: tb/tb_rpn_lexer.sv
module tb_rpn_lexer;

    localparam int CPB_A = 32;
    localparam int NW_A  = 16;
    localparam int CPB_B = 16;
    localparam int NW_B  = 8;

    localparam int K_NUM = 0;
    localparam int K_OP  = 1;
    localparam int K_EOL = 2;
    localparam int K_ERR = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            rx_a;
    logic            rx_b;
    logic            op_ready_a, num_ready_a, num_ovf_a, eol_a, err_a;
    logic [3:0]      op_a;
    logic [NW_A-1:0] num_a;
    logic            op_ready_b, num_ready_b, num_ovf_b, eol_b, err_b;
    logic [3:0]      op_b;
    logic [NW_B-1:0] num_b;

    rpn_lexer #(.CLKS_PER_BIT(CPB_A), .NUM_WIDTH(NW_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_a),
        .op_ready(op_ready_a), .op(op_a),
        .num_ready(num_ready_a), .num(num_a), .num_ovf(num_ovf_a),
        .eol(eol_a), .err(err_a)
    );

    rpn_lexer #(.CLKS_PER_BIT(CPB_B), .NUM_WIDTH(NW_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_b),
        .op_ready(op_ready_b), .op(op_b),
        .num_ready(num_ready_b), .num(num_b), .num_ovf(num_ovf_b),
        .eol(eol_b), .err(err_b)
    );

    // gap: required clocks since the previous strobe of the same DUT, -1 = any
    typedef struct {
        int kind;
        int val;
        int ovf;
        int gap;
    } tok_t;

    typedef struct {
        int    sel;
        string txt;
        int    n;
        tok_t  exp[8];
    } vec_t;

    vec_t vecs[10];
    int   n_vecs = 0;
    tok_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_obs   = 0;
    int last_a  = 0;
    int last_b  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic tok_t mk(input int kind, input int val, input int ovf, input int gap);
        tok_t t;
        t.kind = kind;
        t.val  = val;
        t.ovf  = ovf;
        t.gap  = gap;
        return t;
    endfunction

    task automatic observe(input tok_t o, input int gap, input string who);
        tok_t e;
        n_obs++;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s unexpected_token: got kind=%0d val=%0d ovf=%0d, required no token",
                     who, o.kind, o.val, o.ovf);
        end else begin
            e = exp_q.pop_front();
            if (o.kind != e.kind || (e.kind <= K_OP && o.val != e.val) ||
                (e.kind == K_NUM && o.ovf != e.ovf) || (e.gap >= 0 && gap != e.gap)) begin
                n_fail++;
                $display("FAIL %s token: got kind=%0d val=%0d ovf=%0d gap=%0d, required kind=%0d val=%0d ovf=%0d gap=%0d",
                         who, o.kind, o.val, o.ovf, gap, e.kind, e.val, e.ovf, e.gap);
            end
        end
    endtask

    always @(negedge clk) begin
        int   ns;
        tok_t o;
        ns = int'(op_ready_a) + int'(num_ready_a) + int'(eol_a) + int'(err_a);
        if (ns != 0) begin
            n_tests++;
            if (ns != 1) begin
                n_fail++;
                $display("FAIL A one_strobe: got %0d strobes high, required 1", ns);
            end
            if (num_ready_a)     o = mk(K_NUM, int'(num_a), int'(num_ovf_a), 0);
            else if (op_ready_a) o = mk(K_OP, int'(op_a), 0, 0);
            else if (eol_a)      o = mk(K_EOL, 0, 0, 0);
            else                 o = mk(K_ERR, 0, 0, 0);
            observe(o, cyc - last_a, "A");
            last_a = cyc;
        end
    end

    always @(negedge clk) begin
        int   ns;
        tok_t o;
        ns = int'(op_ready_b) + int'(num_ready_b) + int'(eol_b) + int'(err_b);
        if (ns != 0) begin
            n_tests++;
            if (ns != 1) begin
                n_fail++;
                $display("FAIL B one_strobe: got %0d strobes high, required 1", ns);
            end
            if (num_ready_b)     o = mk(K_NUM, int'(num_b), int'(num_ovf_b), 0);
            else if (op_ready_b) o = mk(K_OP, int'(op_b), 0, 0);
            else if (eol_b)      o = mk(K_EOL, 0, 0, 0);
            else                 o = mk(K_ERR, 0, 0, 0);
            observe(o, cyc - last_b, "B");
            last_b = cyc;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int cpb_of(input int sel);
        return (sel == 0) ? CPB_A : CPB_B;
    endfunction

    task automatic drive(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
    endtask

    task automatic send_byte(input int sel, input logic [7:0] b, input logic stop);
        int c;
        c = cpb_of(sel);
        drive(sel, 1'b0);
        wait_clks(c);
        for (int i = 0; i < 8; i++) begin
            drive(sel, b[i]);
            wait_clks(c);
        end
        drive(sel, stop);
        wait_clks(c);
        drive(sel, 1'b1);
        if (!stop) wait_clks(c);
    endtask

    task automatic send_str(input int sel, input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(sel, s[i], 1'b1);
        end
    endtask

    task automatic check_drained(input string name);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s drained: got %0d tokens still missing, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic set_vec(input int sel, input string txt);
        vecs[n_vecs].sel = sel;
        vecs[n_vecs].txt = txt;
        vecs[n_vecs].n   = 0;
        n_vecs++;
    endtask

    task automatic add_exp(input int kind, input int val, input int ovf, input int gap);
        int k;
        k = n_vecs - 1;
        vecs[k].exp[vecs[k].n] = mk(kind, val, ovf, gap);
        vecs[k].n++;
    endtask

    initial begin
        int n0;
        rst_n = 1'b1;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        #1 rst_n = 1'b0;
        wait_clks(5);

        n_tests++;
        if ({op_ready_a, op_a, num_ready_a, num_a, num_ovf_a, eol_a, err_a} != '0) begin
            n_fail++;
            $display("FAIL A reset_outputs: got op=%0d num=%0d strobes=%b, required all 0",
                     op_a, num_a, {op_ready_a, num_ready_a, num_ovf_a, eol_a, err_a});
        end
        n_tests++;
        if ({op_ready_b, op_b, num_ready_b, num_b, num_ovf_b, eol_b, err_b} != '0) begin
            n_fail++;
            $display("FAIL B reset_outputs: got op=%0d num=%0d strobes=%b, required all 0",
                     op_b, num_b, {op_ready_b, num_ready_b, num_ovf_b, eol_b, err_b});
        end

        rst_n = 1'b1;
        wait_clks(10);

        set_vec(0, "1 12 + 2 *\n");
        add_exp(K_NUM, 1, 0, -1);  add_exp(K_NUM, 12, 0, -1); add_exp(K_OP, 0, 0, -1);
        add_exp(K_NUM, 2, 0, -1);  add_exp(K_OP, 2, 0, -1);   add_exp(K_EOL, 0, 0, -1);
        set_vec(0, "3+4\n");
        add_exp(K_NUM, 3, 0, -1);  add_exp(K_OP, 0, 0, 1);
        add_exp(K_NUM, 4, 0, -1);  add_exp(K_EOL, 0, 0, 1);
        set_vec(0, "65535 65536 999999\n");
        add_exp(K_NUM, 65535, 0, -1); add_exp(K_NUM, 65535, 1, -1);
        add_exp(K_NUM, 65535, 1, -1); add_exp(K_EOL, 0, 0, 1);
        set_vec(0, "12a 5\n");
        add_exp(K_ERR, 0, 0, -1);  add_exp(K_NUM, 5, 0, -1);  add_exp(K_EOL, 0, 0, 1);
        set_vec(0, "0%7-\015\n");
        add_exp(K_NUM, 0, 0, -1);  add_exp(K_OP, 4, 0, 1);
        add_exp(K_NUM, 7, 0, -1);  add_exp(K_OP, 1, 0, 1);    add_exp(K_EOL, 0, 0, -1);
        set_vec(0, "8/9 \n");
        add_exp(K_NUM, 8, 0, -1);  add_exp(K_OP, 3, 0, 1);
        add_exp(K_NUM, 9, 0, -1);  add_exp(K_EOL, 0, 0, -1);
        set_vec(1, "1 12 + 2 *\n");
        add_exp(K_NUM, 1, 0, -1);  add_exp(K_NUM, 12, 0, -1); add_exp(K_OP, 0, 0, -1);
        add_exp(K_NUM, 2, 0, -1);  add_exp(K_OP, 2, 0, -1);   add_exp(K_EOL, 0, 0, -1);
        set_vec(1, "255 256\n");
        add_exp(K_NUM, 255, 0, -1); add_exp(K_NUM, 255, 1, -1); add_exp(K_EOL, 0, 0, 1);

        for (int v = 0; v < n_vecs; v++) begin
            for (int j = 0; j < vecs[v].n; j++) exp_q.push_back(vecs[v].exp[j]);
            send_str(vecs[v].sel, vecs[v].txt);
            wait_clks(4 * cpb_of(vecs[v].sel));
            check_drained($sformatf("vec%0d", v));
        end

        // Outputs hold their last values between strobes.
        n_tests++;
        if (num_a != 16'd9 || op_a != 4'd3) begin
            n_fail++;
            $display("FAIL A hold: got num=%0d op=%0d, required num=9 op=3", num_a, op_a);
        end
        n_tests++;
        if (num_b != 8'd255 || op_b != 4'd2) begin
            n_fail++;
            $display("FAIL B hold: got num=%0d op=%0d, required num=255 op=2", num_b, op_b);
        end

        // Short low pulse on the line must be rejected.
        n0 = n_obs;
        drive(0, 1'b0);
        wait_clks(CPB_A / 4);
        drive(0, 1'b1);
        wait_clks(12 * CPB_A);
        n_tests++;
        if (n_obs != n0) begin
            n_fail++;
            $display("FAIL A glitch: got %0d tokens, required 0", n_obs - n0);
        end

        // Framing error on a lone byte.
        exp_q.push_back(mk(K_ERR, 0, 0, -1));
        exp_q.push_back(mk(K_NUM, 8, 0, -1));
        exp_q.push_back(mk(K_EOL, 0, 0, 1));
        send_byte(0, 8'h37, 1'b0);
        send_str(0, " 8\n");
        wait_clks(4 * CPB_A);
        check_drained("frame_err");

        // Framing error inside a number leaves the pending digits alone.
        exp_q.push_back(mk(K_ERR, 0, 0, -1));
        exp_q.push_back(mk(K_NUM, 5, 0, -1));
        exp_q.push_back(mk(K_NUM, 8, 0, -1));
        exp_q.push_back(mk(K_EOL, 0, 0, 1));
        send_str(0, "5");
        send_byte(0, 8'h37, 1'b0);
        send_str(0, " 8\n");
        wait_clks(4 * CPB_A);
        check_drained("frame_err_mid_num");

        // Reset in the middle of "42", after the '4'.
        send_str(0, "4");
        drive(0, 1'b0);
        wait_clks(CPB_A);
        for (int i = 0; i < 4; i++) begin
            drive(0, (i == 1) ? 1'b1 : 1'b0);
            wait_clks(CPB_A);
        end
        rst_n = 1'b0;
        wait_clks(3);
        n_tests++;
        if (num_a != '0 || op_a != 4'd0) begin
            n_fail++;
            $display("FAIL A mid_reset_clear: got num=%0d op=%0d, required 0 0", num_a, op_a);
        end
        drive(0, 1'b1);
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(4 * CPB_A);
        exp_q.push_back(mk(K_NUM, 7, 0, -1));
        exp_q.push_back(mk(K_EOL, 0, 0, 1));
        send_str(0, "7\n");
        wait_clks(4 * CPB_A);
        check_drained("mid_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
